lcd_i2c_frame_sender: RTL

Downstream stage of the I2C LCD transmitter's AXI4-Lite register file. It accepts one LCD command (RS flag plus data byte) per valid/ready handshake. It expands the command into the four PCF8574 backpack bytes used in 4-bit mode, and drives a complete I2C write frame on open-drain SCL/SDA: START, address, four data bytes, STOP. A NACK aborts the frame and raises a sticky error flag that the register file reads back.

---
 rtl/lcd_i2c_frame_sender_pkg.sv | 54 +++++
 rtl/lcd_i2c_frame_sender_if.sv | 25 ++
 rtl/lcd_i2c_frame_sender_quarter_tick.sv | 30 +++
 rtl/lcd_i2c_frame_sender.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lcd_i2c_frame_sender_pkg.sv
// Shared types and helpers for the LCD I2C frame sender: FSM states, PCF8574
// bit positions, and the per-quarter SCL/SDA levels of each bus phase.
package lcd_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP
  } state_t;

  localparam int BL_BIT = 3;
  localparam int EN_BIT = 2;
  localparam int RW_BIT = 1;
  localparam int RS_BIT = 0;

  // One PCF8574 backpack byte: LCD nibble on P7..P4, control lines on P3..P0.
  function automatic logic [7:0] pcf_byte(input logic [3:0] nibble,
                                          input logic       en,
                                          input logic       rs,
                                          input logic       bl);
    logic [7:0] b;
    b         = {nibble, 4'b0000};
    b[BL_BIT] = bl;
    b[EN_BIT] = en;
    b[RW_BIT] = 1'b0;
    b[RS_BIT] = rs;
    return b;
  endfunction

  // Returns {scl_t, sda_t} for a given phase and quarter; 1 means released.
  function automatic logic [1:0] line_levels(input state_t     st,
                                             input logic [1:0] q,
                                             input logic       tx_bit);
    logic [1:0] lv;
    lv = 2'b11;
    case (st)
      ST_START: lv = (q < 2'd2) ? 2'b10 : 2'b00;
      ST_BIT:   lv = {q[1], tx_bit};
      ST_ACK:   lv = {q[1], 1'b1};
      ST_STOP: begin
        case (q)
          2'd0:    lv = 2'b00;
          2'd1:    lv = 2'b10;
          default: lv = 2'b11;
        endcase
      end
      default:  lv = 2'b11;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/lcd_i2c_frame_sender_if.sv
// Command handshake, status and open-drain pad signals of the frame sender.
interface lcd_i2c_frame_sender_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       busy;
  logic       nack;
  logic       nack_clr;
  logic       scl_t;
  logic       sda_t;
  logic       sda_i;

  modport slave (
    input  cmd_valid, cmd_rs, cmd_data, nack_clr, sda_i,
    output cmd_ready, busy, nack, scl_t, sda_t
  );

  modport master (
    output cmd_valid, cmd_rs, cmd_data, nack_clr, sda_i,
    input  cmd_ready, busy, nack, scl_t, sda_t
  );

endinterface

// File: rtl/lcd_i2c_frame_sender_quarter_tick.sv
// Prescaler that emits a single-cycle pulse every CLK_DIV enabled cycles,
// i.e. once per I2C quarter-bit.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/lcd_i2c_frame_sender.sv
// Turns one LCD command into a five-byte I2C write (address plus four PCF8574
// bytes) on open-drain SCL/SDA; a NACK ends the frame early and sets sticky nack.
module lcd_i2c_frame_sender
  import lcd_i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 250,
  parameter logic [6:0] I2C_ADDR  = 7'h27,
  parameter logic       BACKLIGHT = 1'b1
) (
  input  logic                   i_aclk,
  input  logic                   i_aresetn,
  lcd_i2c_frame_sender_if.slave  bus
);

  localparam logic [7:0] ADDR_BYTE = {I2C_ADDR, 1'b0};

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_q;
  logic [1:0]      w_q_next;
  logic [2:0]      r_bit_cnt;
  logic [2:0]      w_bit_cnt_next;
  logic [2:0]      r_byte_idx;
  logic [2:0]      w_byte_idx_next;
  logic [3:0][7:0] r_data;
  logic            r_nack;
  logic            r_scl_t;
  logic            r_sda_t;

  logic            w_accept;
  logic            w_tick;
  logic            w_tick_en;
  logic            w_nack_set;
  logic [7:0]      w_tx_byte;
  logic            w_tx_bit;
  logic [1:0]      w_lines;

  assign w_accept  = bus.cmd_valid && (r_state == ST_IDLE);
  assign w_tick_en = (r_state != ST_IDLE);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .i_clk   (i_aclk),
    .i_rst_n (i_aresetn),
    .i_en    (w_tick_en),
    .i_clr   (w_accept),
    .o_tick  (w_tick)
  );

  // Every phase lasts four quarters; the phase decision is taken on the last one.
  always_comb begin
    w_state_next    = r_state;
    w_q_next        = r_q;
    w_bit_cnt_next  = r_bit_cnt;
    w_byte_idx_next = r_byte_idx;
    w_nack_set      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next    = ST_START;
          w_q_next        = 2'd0;
          w_bit_cnt_next  = 3'd0;
          w_byte_idx_next = 3'd0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_state_next = ST_BIT;
          end
        end
      end
      ST_BIT: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_next = ST_ACK;
            end
          end
        end
      end
      ST_ACK: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (bus.sda_i) begin
              w_nack_set   = 1'b1;
              w_state_next = ST_STOP;
            end else if (r_byte_idx == 3'd4) begin
              w_state_next = ST_STOP;
            end else begin
              w_byte_idx_next = r_byte_idx + 3'd1;
              w_state_next    = ST_BIT;
            end
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_q_next = r_q + 2'd1;
          if (r_q == 2'd3) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Line levels follow the next phase/quarter so the pads are registered outputs.
  always_comb begin
    w_tx_byte = ADDR_BYTE;
    case (w_byte_idx_next)
      3'd1:    w_tx_byte = r_data[0];
      3'd2:    w_tx_byte = r_data[1];
      3'd3:    w_tx_byte = r_data[2];
      3'd4:    w_tx_byte = r_data[3];
      default: w_tx_byte = ADDR_BYTE;
    endcase
    w_tx_bit = w_tx_byte[3'd7 - w_bit_cnt_next];
    w_lines  = line_levels(w_state_next, w_q_next, w_tx_bit);
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= ST_IDLE;
      r_q        <= 2'd0;
      r_bit_cnt  <= 3'd0;
      r_byte_idx <= 3'd0;
      r_data     <= '0;
      r_nack     <= 1'b0;
      r_scl_t    <= 1'b1;
      r_sda_t    <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_q        <= w_q_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_byte_idx <= w_byte_idx_next;
      r_scl_t    <= w_lines[1];
      r_sda_t    <= w_lines[0];
      if (w_accept) begin
        r_data <= {pcf_byte(bus.cmd_data[3:0], 1'b0, bus.cmd_rs, BACKLIGHT),
                   pcf_byte(bus.cmd_data[3:0], 1'b1, bus.cmd_rs, BACKLIGHT),
                   pcf_byte(bus.cmd_data[7:4], 1'b0, bus.cmd_rs, BACKLIGHT),
                   pcf_byte(bus.cmd_data[7:4], 1'b1, bus.cmd_rs, BACKLIGHT)};
      end
      if (w_nack_set) begin
        r_nack <= 1'b1;
      end else if (bus.nack_clr) begin
        r_nack <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.nack      = r_nack;
  assign bus.scl_t     = r_scl_t;
  assign bus.sda_t     = r_sda_t;

endmodule
